// File: rtl/id_stage_if.sv
// Signal bundle between the DLX instruction-decode stage and its neighbours:
// fetch inputs, hazard/writeback inputs, and decoded outputs toward ID/EX.
interface id_stage_if #(
    parameter int STALL_CNT_W = 16
);
    logic [31:0]            if_instr;
    logic [31:0]            if_npc;
    logic                   flush;
    logic                   ex_mem_read;
    logic [4:0]             ex_rt;
    logic                   wb_en;
    logic [4:0]             wb_addr;
    logic [31:0]            wb_data;

    logic                   pc_write;
    logic [31:0]            a;
    logic [31:0]            b;
    logic [31:0]            npc;
    logic [31:0]            imm;
    logic [4:0]             rd1;
    logic [4:0]             rd2;
    logic                   regdst;
    logic                   alusrc;
    logic [1:0]             aluop;
    logic                   branch;
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_write;
    logic                   mem_to_reg;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output if_instr, if_npc, flush, ex_mem_read, ex_rt, wb_en, wb_addr, wb_data,
        input  pc_write, a, b, npc, imm, rd1, rd2, regdst, alusrc, aluop,
               branch, mem_read, mem_write, reg_write, mem_to_reg, stall_count
    );

    modport slave (
        input  if_instr, if_npc, flush, ex_mem_read, ex_rt, wb_en, wb_addr, wb_data,
        output pc_write, a, b, npc, imm, rd1, rd2, regdst, alusrc, aluop,
               branch, mem_read, mem_write, reg_write, mem_to_reg, stall_count
    );
endinterface

// File: rtl/id_stage.sv
// DLX decode stage: IF/ID register, 32x32 register file with write-through
// bypass, main control decoder and load-use hazard detection with bubble insertion.
module id_stage #(
    parameter int REG_COUNT   = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    id_stage_if.slave  bus
);
    logic [31:0]            id_instr_reg;
    logic [31:0]            id_npc_reg;
    logic [31:0]            regs_reg [REG_COUNT];
    logic [STALL_CNT_W-1:0] stall_cnt_reg;
    logic [REG_COUNT-1:0]   wr_sel;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       is_rtype;
    logic       uses_rt;
    logic       stall;
    logic       wb_hit;

    assign opcode   = id_instr_reg[31:26];
    assign rs       = id_instr_reg[25:21];
    assign rt       = id_instr_reg[20:16];
    assign is_rtype = (opcode == 6'h00) && (id_instr_reg != 32'd0);
    assign uses_rt  = is_rtype || (opcode == 6'h2B);

    // Flush wins over stall so a killed instruction never holds the PC.
    assign stall = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                   ((bus.ex_rt == rs) || (uses_rt && (bus.ex_rt == rt))) && !bus.flush;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            id_instr_reg <= '0;
            id_npc_reg   <= '0;
        end else if (bus.flush) begin
            id_instr_reg <= '0;
            id_npc_reg   <= '0;
        end else if (!stall) begin
            id_instr_reg <= bus.if_instr;
            id_npc_reg   <= bus.if_npc;
        end
    end

    // Per-register write strobe; r0 is never written.
    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_r0
                assign wr_sel[gi] = 1'b0;
            end else begin : g_rn
                assign wr_sel[gi] = bus.wb_en && (bus.wb_addr == 5'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs_reg[i] <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (wr_sel[i]) regs_reg[i] <= bus.wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign wb_hit = bus.wb_en && (bus.wb_addr != 5'd0);

    assign bus.a = (rs == 5'd0) ? 32'd0 :
                   (wb_hit && (bus.wb_addr == rs)) ? bus.wb_data : regs_reg[rs];
    assign bus.b = (rt == 5'd0) ? 32'd0 :
                   (wb_hit && (bus.wb_addr == rt)) ? bus.wb_data : regs_reg[rt];

    assign bus.npc         = id_npc_reg;
    assign bus.imm         = {{16{id_instr_reg[15]}}, id_instr_reg[15:0]};
    assign bus.rd1         = rt;
    assign bus.rd2         = id_instr_reg[15:11];
    assign bus.pc_write    = !stall;
    assign bus.stall_count = stall_cnt_reg;

    // Control decode; a stall turns the decoded instruction into a bubble.
    always_comb begin
        bus.regdst     = 1'b0;
        bus.alusrc     = 1'b0;
        bus.aluop      = 2'b00;
        bus.branch     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        if (!stall) begin
            case (opcode)
                6'h00: begin
                    if (is_rtype) begin
                        bus.regdst    = 1'b1;
                        bus.aluop     = 2'b10;
                        bus.reg_write = 1'b1;
                    end
                end
                6'h23: begin
                    bus.alusrc     = 1'b1;
                    bus.mem_read   = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    bus.reg_write  = 1'b1;
                end
                6'h2B: begin
                    bus.alusrc    = 1'b1;
                    bus.mem_write = 1'b1;
                end
                6'h08: begin
                    bus.alusrc    = 1'b1;
                    bus.reg_write = 1'b1;
                end
                6'h04: begin
                    bus.branch = 1'b1;
                    bus.aluop  = 2'b01;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// compared against a behavioural pipeline model.
module tb_id_stage;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    id_stage_if #(.STALL_CNT_W(16)) bus ();
    id_stage_if #(.STALL_CNT_W(2))  bus_s ();

    id_stage #(.REG_COUNT(32), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave));
    id_stage #(.REG_COUNT(32), .STALL_CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(bus_s.slave));

    assign bus_s.if_instr    = bus.if_instr;
    assign bus_s.if_npc      = bus.if_npc;
    assign bus_s.flush       = bus.flush;
    assign bus_s.ex_mem_read = bus.ex_mem_read;
    assign bus_s.ex_rt       = bus.ex_rt;
    assign bus_s.wb_en       = bus.wb_en;
    assign bus_s.wb_addr     = bus.wb_addr;
    assign bus_s.wb_data     = bus.wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_npc   = 32'd0;
    int unsigned m_cnt   = 0;
    int unsigned m_cnt2  = 0;

    function automatic logic [31:0] rtype(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] im);
        return {op, 5'(rs), 5'(rt), im};
    endfunction

    // Control word {regdst, alusrc, aluop[1:0], branch, mem_read, mem_write, reg_write, mem_to_reg}
    function automatic logic [8:0] m_ctrl(input logic [31:0] ins);
        if (ins == 32'd0) return 9'd0;
        case (ins[31:26])
            6'h00:   return 9'b1_0_10_0_0_0_1_0;
            6'h23:   return 9'b0_1_00_0_1_0_1_1;
            6'h2B:   return 9'b0_1_00_0_0_1_0_0;
            6'h08:   return 9'b0_1_00_0_0_0_1_0;
            6'h04:   return 9'b0_0_01_1_0_0_0_0;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
        return m_regs[idx];
    endfunction

    function automatic logic m_stall();
        logic [4:0] rs;
        logic [4:0] rt;
        logic       needs_rt;
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        needs_rt = (m_instr[31:26] == 6'h00 && m_instr != 32'd0) || m_instr[31:26] == 6'h2B;
        return bus.ex_mem_read && bus.ex_rt != 5'd0 && !bus.flush &&
               (bus.ex_rt == rs || (needs_rt && bus.ex_rt == rt));
    endfunction

    function automatic logic [163:0] m_vec();
        logic st;
        st = m_stall();
        return {!st, m_read(m_instr[25:21]), m_read(m_instr[20:16]), m_npc,
                {{16{m_instr[15]}}, m_instr[15:0]}, m_instr[20:16], m_instr[15:11],
                (st ? 9'd0 : m_ctrl(m_instr)), 16'(m_cnt)};
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {bus.regdst, bus.alusrc, bus.aluop, bus.branch, bus.mem_read,
                bus.mem_write, bus.reg_write, bus.mem_to_reg};
    endfunction

    function automatic logic [163:0] dut_vec();
        return {bus.pc_write, bus.a, bus.b, bus.npc, bus.imm, bus.rd1, bus.rd2,
                dut_ctrl(), bus.stall_count};
    endfunction

    task automatic set_idle();
        bus.flush = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rt = 5'd0;
        bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
    endtask

    // Advance one clock, updating the model from the inputs seen before the edge.
    task automatic tick();
        logic st, rst, we, fl;
        logic [4:0]  wa;
        logic [31:0] wd, ii, inp;
        st = m_stall(); rst = !reset_n; fl = bus.flush;
        we = bus.wb_en; wa = bus.wb_addr; wd = bus.wb_data;
        ii = bus.if_instr; inp = bus.if_npc;
        @(posedge clk);
        if (rst) begin
            m_instr = 32'd0; m_npc = 32'd0; m_cnt = 0; m_cnt2 = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            if (fl) begin
                m_instr = 32'd0; m_npc = 32'd0;
            end else if (!st) begin
                m_instr = ii; m_npc = inp;
            end
            if (st) begin
                if (m_cnt != 65535) m_cnt = m_cnt + 1;
                if (m_cnt2 != 3) m_cnt2 = m_cnt2 + 1;
            end
            if (we && wa != 5'd0) m_regs[wa] = wd;
        end
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        reset_n = 1'b0; bus.if_instr = 32'h8C220004; bus.if_npc = 32'h104;
        tick(); tick();
        #1;
        n_checks++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write: got %b expected 1", bus.pc_write); end
        n_checks++; if ({bus.a, bus.b, bus.npc, bus.imm} !== 128'd0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h expected 0", bus.a, bus.b, bus.npc, bus.imm); end
        n_checks++; if ({bus.rd1, bus.rd2} !== 10'd0) begin n_fail++; $display("FAIL reset_rd: got %h %h expected 0", bus.rd1, bus.rd2); end
        n_checks++; if (dut_ctrl() !== 9'd0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0", dut_ctrl()); end
        n_checks++; if (bus.stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.stall_count); end
        reset_n = 1'b1;
        tick();
        n_checks++; if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL lw_mem_read: got %b expected 1", bus.mem_read); end
        n_checks++; if (bus.imm !== 32'd4) begin n_fail++; $display("FAIL lw_imm: got %h expected 4", bus.imm); end
        n_checks++; if (bus.rd1 !== 5'd2) begin n_fail++; $display("FAIL lw_rd1: got %0d expected 2", bus.rd1); end
        n_checks++; if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL lw_vec: got %h expected %h", dut_vec(), m_vec()); end
    endtask

    task automatic test_regfile();
        set_idle();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
        bus.if_instr = rtype(3, 5, 0); bus.if_npc = 32'h200;
        tick();
        set_idle(); #1;
        n_checks++; if (bus.a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rf_a: got %h expected deadbeef", bus.a); end
        n_checks++; if (bus.b !== 32'd0) begin n_fail++; $display("FAIL rf_b: got %h expected 0", bus.b); end
        bus.if_instr = rtype(1, 6, 0);
        tick();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h1234; #1;
        n_checks++; if (bus.a !== 32'h1234) begin n_fail++; $display("FAIL bypass_a: got %h expected 1234", bus.a); end
        n_checks++; if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL bypass_vec: got %h expected %h", dut_vec(), m_vec()); end
        tick();
        set_idle(); #1;
        n_checks++; if (bus.a !== 32'h1234) begin n_fail++; $display("FAIL rf_after_wb: got %h expected 1234", bus.a); end
        bus.if_instr = rtype(2, 0, 0);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFFFFFF;
        tick(); #1;
        n_checks++; if ({bus.a, bus.b} !== 64'd0) begin n_fail++; $display("FAIL r0_zero: got %h %h expected 0", bus.a, bus.b); end
        set_idle();
    endtask

    task automatic test_load_use();
        int unsigned cnt0;
        set_idle();
        bus.if_instr = rtype(4, 2, 3); bus.if_npc = 32'h300;
        tick();
        bus.if_instr = itype(6'h08, 1, 9, 16'h55); bus.if_npc = 32'h304;
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd2; #1;
        cnt0 = m_cnt;
        n_checks++; if (bus.pc_write !== 1'b0) begin n_fail++; $display("FAIL stall_pc_write: got %b expected 0", bus.pc_write); end
        n_checks++; if (dut_ctrl() !== 9'd0) begin n_fail++; $display("FAIL stall_bubble: got %b expected 0", dut_ctrl()); end
        n_checks++; if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL stall_vec: got %h expected %h", dut_vec(), m_vec()); end
        tick();
        bus.ex_mem_read = 1'b0; #1;
        n_checks++; if (bus.stall_count !== 16'(cnt0 + 1)) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", bus.stall_count, cnt0 + 1); end
        n_checks++; if (bus.rd2 !== 5'd4 || bus.npc !== 32'h300) begin n_fail++; $display("FAIL stall_hold: got rd2=%0d npc=%h expected 4 300", bus.rd2, bus.npc); end
        n_checks++; if (bus.regdst !== 1'b1 || bus.aluop !== 2'b10) begin n_fail++; $display("FAIL redecode: got regdst=%b aluop=%b expected 1 10", bus.regdst, bus.aluop); end
        n_checks++; if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL redecode_vec: got %h expected %h", dut_vec(), m_vec()); end
        tick();
    endtask

    task automatic test_no_false_stall();
        set_idle();
        bus.if_instr = itype(6'h08, 1, 2, 16'h10);
        tick();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd2; bus.if_instr = rtype(4, 0, 0); #1;
        n_checks++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL addi_no_stall: got %b expected 1", bus.pc_write); end
        n_checks++; if (bus.alusrc !== 1'b1 || bus.reg_write !== 1'b1) begin n_fail++; $display("FAIL addi_ctrl: got %b expected alusrc,reg_write set", dut_ctrl()); end
        tick();
        bus.ex_rt = 5'd0; #1;
        n_checks++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL rt0_no_stall: got %b expected 1", bus.pc_write); end
        n_checks++; if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL rt0_vec: got %h expected %h", dut_vec(), m_vec()); end
        set_idle();
    endtask

    task automatic test_flush();
        int unsigned cnt0;
        set_idle();
        bus.if_instr = rtype(4, 2, 3); bus.if_npc = 32'h400;
        tick();
        bus.if_instr = itype(6'h23, 1, 2, 16'h4); bus.if_npc = 32'h404;
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd2; bus.flush = 1'b1; #1;
        cnt0 = m_cnt;
        n_checks++; if (bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL flush_pc_write: got %b expected 1", bus.pc_write); end
        tick();
        set_idle(); #1;
        n_checks++; if (bus.npc !== 32'd0 || dut_ctrl() !== 9'd0) begin n_fail++; $display("FAIL flush_nop: got npc=%h ctrl=%b expected 0 0", bus.npc, dut_ctrl()); end
        n_checks++; if (bus.stall_count !== 16'(cnt0)) begin n_fail++; $display("FAIL flush_count: got %0d expected %0d", bus.stall_count, cnt0); end
    endtask

    task automatic test_imm();
        set_idle();
        bus.if_instr = itype(6'h08, 3, 4, 16'h8000);
        tick();
        n_checks++; if (bus.imm !== 32'hFFFF8000) begin n_fail++; $display("FAIL imm_neg: got %h expected ffff8000", bus.imm); end
        bus.if_instr = itype(6'h2B, 3, 4, 16'h7FFF);
        tick();
        n_checks++; if (bus.imm !== 32'h00007FFF) begin n_fail++; $display("FAIL imm_pos: got %h expected 00007fff", bus.imm); end
        n_checks++; if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL sw_vec: got %h expected %h", dut_vec(), m_vec()); end
    endtask

    task automatic test_saturation();
        set_idle();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        bus.if_instr = rtype(4, 2, 3);
        tick();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd2;
        repeat (5) tick();
        n_checks++; if (bus_s.stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_small: got %0d expected 3", bus_s.stall_count); end
        n_checks++; if (bus.stall_count !== 16'd5) begin n_fail++; $display("FAIL sat_wide: got %0d expected 5", bus.stall_count); end
        set_idle();
    endtask

    task automatic test_reset_mid_stall();
        set_idle();
        bus.if_instr = rtype(4, 2, 3);
        tick();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd2; #1;
        n_checks++; if (bus.pc_write !== 1'b0) begin n_fail++; $display("FAIL pre_reset_stall: got %b expected 0", bus.pc_write); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; set_idle(); bus.if_instr = rtype(5, 1, 1); #1;
        n_checks++; if (bus.stall_count !== 16'd0 || bus.npc !== 32'd0 || bus.rd2 !== 5'd0) begin n_fail++; $display("FAIL mid_stall_reset: got cnt=%0d npc=%h rd2=%0d expected 0 0 0", bus.stall_count, bus.npc, bus.rd2); end
        n_checks++; if (dut_ctrl() !== 9'd0 || bus.pc_write !== 1'b1) begin n_fail++; $display("FAIL post_reset_nop: got ctrl=%b pc_write=%b expected 0 1", dut_ctrl(), bus.pc_write); end
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        logic [5:0] op;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h08; ops[4] = 6'h04; ops[5] = 6'h3F;
        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 15) == 0)
                bus.if_instr = 32'd0;
            else if (op == 6'h00)
                bus.if_instr = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            else
                bus.if_instr = itype(op, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
            bus.if_npc      = $urandom;
            bus.flush       = ($urandom_range(0, 9) == 0);
            bus.ex_mem_read = 1'($urandom_range(0, 1));
            bus.ex_rt       = 5'($urandom_range(0, 7));
            bus.wb_en       = 1'($urandom_range(0, 1));
            bus.wb_addr     = 5'($urandom_range(0, 7));
            bus.wb_data     = $urandom;
            reset_n         = ($urandom_range(0, 59) != 0);
            #1;
            n_checks++; if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL random_vec[%0d]: got %h expected %h", n, dut_vec(), m_vec()); end
            n_checks++; if (bus_s.stall_count !== 2'(m_cnt2)) begin n_fail++; $display("FAIL random_small_cnt[%0d]: got %0d expected %0d", n, bus_s.stall_count, m_cnt2); end
            tick();
        end
        reset_n = 1'b1;
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        bus.if_instr = 32'd0; bus.if_npc = 32'd0;
        set_idle();
        test_reset();
        test_regfile();
        test_load_use();
        test_no_false_stall();
        test_flush();
        test_imm();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
